lut_config_loader: RTL and testbench

//  Configuration writer for the 4-input LUT config port (addr/data/enable strobe interface).

---
 rtl/lut_config_loader.sv | 131 +++++++++++++
 tb/tb_lut_config_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_config_loader.sv
// Serial truth-table loader for a chain of LUT config ports. Each accepted bit is written with a
// setup/strobe/hold sequence so level-sensitive LUT storage only ever sees stable addr/data.
module lut_config_loader #(
  parameter int unsigned LUT_K  = 4,
  parameter int unsigned N_LUTS = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_bit,
  input  logic              i_bit_valid,
  output logic              o_bit_ready,
  output logic [LUT_K-1:0]  o_addr_load_data,
  output logic              o_data,
  output logic [N_LUTS-1:0] o_config_enable,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned LutCntW = (N_LUTS > 1) ? $clog2(N_LUTS) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StWaitBit,
    StSetup,
    StStrobe,
    StHold,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [LUT_K-1:0]    bit_cnt_q, bit_cnt_d;
  logic [LutCntW-1:0]  lut_cnt_q, lut_cnt_d;
  logic [LUT_K-1:0]    addr_q, addr_d;
  logic                data_q, data_d;
  logic [N_LUTS-1:0]   enable_q, enable_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                last_bit;

  assign last_bit = (bit_cnt_q == '1) && (lut_cnt_q == LutCntW'(N_LUTS - 1));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    lut_cnt_d = lut_cnt_q;

    case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d   = StWaitBit;
          bit_cnt_d = '0;
          lut_cnt_d = '0;
        end
      end
      StWaitBit: begin
        if (i_bit_valid && ready_q) begin
          state_d = StSetup;
        end
      end
      StSetup:  state_d = StStrobe;
      StStrobe: state_d = StHold;
      StHold: begin
        if (last_bit) begin
          state_d = StDone;
        end else begin
          state_d   = StWaitBit;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == '1) begin
            lut_cnt_d = lut_cnt_q + 1'b1;
          end
        end
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Abort overrides everything, including a simultaneous start in IDLE.
    if (i_abort) begin
      state_d = StIdle;
    end
  end

  // Output registers are computed from the next state so every output is a flop.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if ((state_q == StWaitBit) && (state_d == StSetup)) begin
      addr_d = bit_cnt_q;
      data_d = i_bit;
    end
    enable_d = (state_d == StStrobe) ? (N_LUTS'(1) << lut_cnt_q) : '0;
    ready_d  = (state_d == StWaitBit);
    busy_d   = (state_d != StIdle);
    done_d   = (state_d == StDone);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      lut_cnt_q <= '0;
      addr_q    <= '0;
      data_q    <= 1'b0;
      enable_q  <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      lut_cnt_q <= lut_cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      enable_q  <= enable_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_bit_ready      = ready_q;
  assign o_addr_load_data = addr_q;
  assign o_data           = data_q;
  assign o_config_enable  = enable_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;

endmodule

// File: tb/tb_lut_config_loader.sv
// Bench for lut_config_loader: one single-LUT and one two-LUT instance share stimulus; a
// per-bit timing model and a LUT storage model built from the observed strobes check each load.
module tb_lut_config_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       bit_in;
  logic       bit_valid;

  logic       ready1, data1, en1, busy1, done1;
  logic [3:0] addr1;
  logic       ready2, data2, busy2, done2;
  logic [1:0] en2;
  logic [3:0] addr2;

  int unsigned n_checks;
  int unsigned n_pass;
  int unsigned sel;

  logic        s_ready, s_data, s_busy, s_done;
  logic [3:0]  s_addr;
  logic [1:0]  s_en;
  logic [15:0] lut_model [2];
  logic [31:0] stream_w;

  lut_config_loader #(.LUT_K(4), .N_LUTS(1)) u_dut1 (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_start          (start),
    .i_abort          (abort),
    .i_bit            (bit_in),
    .i_bit_valid      (bit_valid),
    .o_bit_ready      (ready1),
    .o_addr_load_data (addr1),
    .o_data           (data1),
    .o_config_enable  (en1),
    .o_busy           (busy1),
    .o_done           (done1)
  );

  lut_config_loader #(.LUT_K(4), .N_LUTS(2)) u_dut2 (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_start          (start),
    .i_abort          (abort),
    .i_bit            (bit_in),
    .i_bit_valid      (bit_valid),
    .o_bit_ready      (ready2),
    .o_addr_load_data (addr2),
    .o_data           (data2),
    .o_config_enable  (en2),
    .o_busy           (busy2),
    .o_done           (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (sel == 0) begin
      s_ready = ready1; s_data = data1; s_busy = busy1; s_done = done1;
      s_addr = addr1; s_en = {1'b0, en1};
    end else begin
      s_ready = ready2; s_data = data2; s_busy = busy2; s_done = done2;
      s_addr = addr2; s_en = en2;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives one full load of nbits from stream_w and checks every cycle against the per-bit model:
  // after a handshake, SETUP/STROBE/HOLD occupy 3 cycles, then ready (or done) on the 4th.
  task automatic load_stream(input int unsigned nbits, input bit gaps,
                             input int unsigned start_again);
    int unsigned sent = 0;
    int unsigned k = 4;
    int unsigned cyc = 0;
    int unsigned dones = 0;
    bit          hs;
    logic        exp_ready, exp_done, exp_data;
    logic [1:0]  exp_en;
    logic [3:0]  exp_addr;
    lut_model[0] = '0;
    lut_model[1] = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (cyc < 2000) begin
      exp_ready = (k >= 4) && (sent < nbits);
      exp_done  = (k == 4) && (sent == nbits);
      exp_en    = (k == 2) ? (2'b01 << ((sent - 1) / 16)) : 2'b00;
      n_checks++;
      if (s_ready !== exp_ready) $display("FAIL ready cyc=%0d got=%b want=%b", cyc, s_ready, exp_ready);
      else n_pass++;
      n_checks++;
      if (s_done !== exp_done) $display("FAIL done cyc=%0d got=%b want=%b", cyc, s_done, exp_done);
      else n_pass++;
      n_checks++;
      if (s_busy !== 1'b1) $display("FAIL busy_in_load cyc=%0d got=%b want=1", cyc, s_busy);
      else n_pass++;
      n_checks++;
      if (s_en !== exp_en) $display("FAIL enable cyc=%0d got=%b want=%b", cyc, s_en, exp_en);
      else n_pass++;
      if (sent > 0) begin
        exp_addr = 4'((sent - 1) % 16);
        exp_data = stream_w[sent-1];
        n_checks++;
        if (s_addr !== exp_addr || s_data !== exp_data)
          $display("FAIL addr_data bit=%0d got=%h/%b want=%h/%b", sent - 1, s_addr, s_data,
                   exp_addr, exp_data);
        else n_pass++;
      end
      if (s_en[0]) lut_model[0][s_addr] = s_data;
      if (s_en[1]) lut_model[1][s_addr] = s_data;
      if (s_done) dones++;
      if (exp_done) break;
      start     = (start_again != 0 && cyc == start_again);
      bit_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bit_in    = (sent < nbits) ? stream_w[sent] : 1'b0;
      hs        = s_ready && bit_valid;
      @(negedge clk);
      cyc++;
      if (hs) begin
        sent++;
        k = 1;
      end else begin
        k++;
      end
    end
    start = 1'b0;
    bit_valid = 1'b0;
    n_checks++;
    if (sent !== nbits || dones !== 1)
      $display("FAIL load_complete got sent=%0d dones=%0d want %0d/1", sent, dones, nbits);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (s_busy !== 1'b0 || s_done !== 1'b0)
      $display("FAIL after_done got busy=%b done=%b want 0/0", s_busy, s_done);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; abort = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ready1, addr1, data1, en1, busy1, done1} !== 9'b0)
        $display("FAIL reset_dut1 got=%b want=0", {ready1, addr1, data1, en1, busy1, done1});
      else n_pass++;
      n_checks++;
      if ({ready2, addr2, data2, en2, busy2, done2} !== 10'b0)
        $display("FAIL reset_dut2 got=%b want=0", {ready2, addr2, data2, en2, busy2, done2});
      else n_pass++;
    end
    start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_lut();
    sel = 0;
    do_reset();
    stream_w = 32'h0000_8000;
    load_stream(16, 1'b0, 0);
    n_checks++;
    if (lut_model[0] !== 16'h8000) $display("FAIL lut_8000 got=%h want=8000", lut_model[0]);
    else n_pass++;
  endtask

  task automatic test_gaps_xor();
    logic [15:0] exp_lut;
    sel = 0;
    do_reset();
    for (int a = 0; a < 16; a++) exp_lut[a] = ^(4'(a));
    stream_w = {16'h0, exp_lut};
    load_stream(16, 1'b1, 0);
    n_checks++;
    if (lut_model[0] !== exp_lut) $display("FAIL lut_xor4 got=%h want=%h", lut_model[0], exp_lut);
    else n_pass++;
  endtask

  task automatic test_two_luts();
    sel = 1;
    do_reset();
    stream_w = {16'hF0F0, 16'h00FF};
    load_stream(32, 1'b1, 0);
    n_checks++;
    if (lut_model[0] !== 16'h00FF || lut_model[1] !== 16'hF0F0)
      $display("FAIL lut_chain got=%h,%h want=00ff,f0f0", lut_model[0], lut_model[1]);
    else n_pass++;
  endtask

  task automatic test_abort();
    int unsigned strobes = 0;
    int unsigned cyc = 0;
    sel = 0;
    do_reset();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    bit_valid = 1'b1;
    while (strobes < 5 && cyc < 100) begin
      bit_in = 1'($urandom);
      @(negedge clk);
      cyc++;
      if (s_en != 2'b00) strobes++;
    end
    n_checks++;
    if (strobes !== 5) $display("FAIL abort_reach got=%0d strobes want=5", strobes);
    else n_pass++;
    abort = 1'b1;
    bit_valid = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if ({s_busy, s_en, s_ready, s_done} !== 5'b0)
      $display("FAIL abort_idle got=%b want=00000", {s_busy, s_en, s_ready, s_done});
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({s_busy, s_en, s_done} !== 4'b0)
        $display("FAIL abort_quiet got=%b want=0000", {s_busy, s_en, s_done});
      else n_pass++;
    end
    stream_w = {16'h0, 16'($urandom)};
    load_stream(16, 1'b0, 0);
    n_checks++;
    if (lut_model[0] !== stream_w[15:0])
      $display("FAIL abort_reload got=%h want=%h", lut_model[0], stream_w[15:0]);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    sel = 0;
    do_reset();
    stream_w = {16'h0, 16'($urandom)};
    load_stream(16, 1'b1, 9);
    n_checks++;
    if (lut_model[0] !== stream_w[15:0])
      $display("FAIL restart_lut got=%h want=%h", lut_model[0], stream_w[15:0]);
    else n_pass++;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({busy1, ready1, busy2, ready2} !== 4'b0)
        $display("FAIL start_abort_idle got=%b want=0000", {busy1, ready1, busy2, ready2});
      else n_pass++;
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    sel = 0;
    test_reset();
    test_single_lut();
    test_gaps_xor();
    test_two_luts();
    test_abort();
    test_start_ignored();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
